// File: rtl/ysyx_25020037_wbu.sv
// Write-back stage: takes one retiring instruction from the LSU and formats load data.
// It drives GPR/CSR commit strobes, the IFU redirect pc, a retire counter and a sticky halt flag.
module ysyx_25020037_wbu #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lsu_valid,
    output logic             wbu_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_dnpc,
    input  logic [4:0]       in_rd,
    input  logic             in_gpr_wen,
    input  logic             in_is_load,
    input  logic             in_is_csr,
    input  logic [2:0]       in_ld_funct3,
    input  logic [1:0]       in_addr_lo,
    input  logic [31:0]      in_mem_rdata,
    input  logic [31:0]      in_alu_result,
    input  logic [31:0]      in_csr_rdata,
    input  logic [31:0]      in_csr_wdata,
    input  logic [5:0]       in_csr_wen,
    input  logic             in_ecall,
    input  logic             in_mret,
    input  logic             in_ebreak,
    input  logic [31:0]      mtvec,
    input  logic [31:0]      mepc,
    output logic             wbu_valid,
    input  logic             gpr_ready,
    output logic             gpr_wen,
    output logic [4:0]       rd,
    output logic [31:0]      gpr_wdata,
    output logic [5:0]       csr_wen,
    output logic [31:0]      csr_wcsr_data,
    output logic             ecall_en,
    output logic             mret_en,
    output logic [31:0]      pc,
    output logic [31:0]      npc,
    output logic             npc_valid,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             halt
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic               gpr_wen_q, gpr_wen_d;
    logic [4:0]         rd_q, rd_d;
    logic [31:0]        gpr_wdata_q, gpr_wdata_d;
    logic [5:0]         csr_wen_q, csr_wen_d;
    logic [31:0]        csr_wdata_q, csr_wdata_d;
    logic               ecall_q, ecall_d;
    logic               mret_q, mret_d;
    logic               ebreak_q, ebreak_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        dnpc_q, dnpc_d;
    logic [31:0]        npc_q, npc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               halt_q, halt_d;

    logic               accept;
    logic               commit;
    logic [31:0]        ld_sh;
    logic [31:0]        ld_data;
    logic [31:0]        wdata_sel;

    assign wbu_valid     = (state_q == BUSY);
    assign wbu_ready     = ~halt_q & (~wbu_valid | gpr_ready);
    assign commit        = wbu_valid & gpr_ready;
    assign accept        = lsu_valid & wbu_ready;
    assign npc_valid     = commit;

    assign gpr_wen       = gpr_wen_q;
    assign rd            = rd_q;
    assign gpr_wdata     = gpr_wdata_q;
    assign csr_wen       = csr_wen_q;
    assign csr_wcsr_data = csr_wdata_q;
    assign ecall_en      = ecall_q;
    assign mret_en       = mret_q;
    assign pc            = pc_q;
    assign npc           = npc_q;
    assign retire_cnt    = cnt_q;
    assign halt          = halt_q;

    // Align the loaded byte/half to bit 0, then extend by access type.
    always_comb begin
        ld_sh   = in_mem_rdata >> {in_addr_lo, 3'b000};
        ld_data = 32'h0;
        case (in_ld_funct3)
            3'b000:  ld_data = {{24{ld_sh[7]}}, ld_sh[7:0]};
            3'b001:  ld_data = {{16{ld_sh[15]}}, ld_sh[15:0]};
            3'b010:  ld_data = in_mem_rdata;
            3'b100:  ld_data = {24'h0, ld_sh[7:0]};
            3'b101:  ld_data = {16'h0, ld_sh[15:0]};
            default: ld_data = 32'h0;
        endcase
        if (in_is_load) begin
            wdata_sel = ld_data;
        end else if (in_is_csr) begin
            wdata_sel = in_csr_rdata;
        end else begin
            wdata_sel = in_alu_result;
        end
    end

    // Next state: commit retires the held instruction, accept loads a new one.
    always_comb begin
        state_d     = state_q;
        gpr_wen_d   = gpr_wen_q;
        rd_d        = rd_q;
        gpr_wdata_d = gpr_wdata_q;
        csr_wen_d   = csr_wen_q;
        csr_wdata_d = csr_wdata_q;
        ecall_d     = ecall_q;
        mret_d      = mret_q;
        ebreak_d    = ebreak_q;
        pc_d        = pc_q;
        dnpc_d      = dnpc_q;
        npc_d       = npc_q;
        cnt_d       = cnt_q;
        halt_d      = halt_q;
        if (commit) begin
            cnt_d   = cnt_q + CNT_W'(1);
            halt_d  = halt_q | ebreak_q;
            state_d = IDLE;
            if (ecall_q) begin
                npc_d = mtvec;
            end else if (mret_q) begin
                npc_d = mepc;
            end else begin
                npc_d = dnpc_q;
            end
        end
        if (accept) begin
            state_d     = BUSY;
            gpr_wen_d   = in_gpr_wen & (in_rd != 5'd0);
            rd_d        = in_rd;
            gpr_wdata_d = wdata_sel;
            csr_wen_d   = in_csr_wen;
            csr_wdata_d = in_csr_wdata;
            ecall_d     = in_ecall;
            mret_d      = in_mret;
            ebreak_d    = in_ebreak;
            pc_d        = in_pc;
            dnpc_d      = in_dnpc;
        end
    end

    // State and output registers; reset drops any pending instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            gpr_wen_q   <= 1'b0;
            rd_q        <= 5'd0;
            gpr_wdata_q <= 32'h0;
            csr_wen_q   <= 6'h0;
            csr_wdata_q <= 32'h0;
            ecall_q     <= 1'b0;
            mret_q      <= 1'b0;
            ebreak_q    <= 1'b0;
            pc_q        <= 32'h0;
            dnpc_q      <= 32'h0;
            npc_q       <= RESET_PC;
            cnt_q       <= '0;
            halt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gpr_wen_q   <= gpr_wen_d;
            rd_q        <= rd_d;
            gpr_wdata_q <= gpr_wdata_d;
            csr_wen_q   <= csr_wen_d;
            csr_wdata_q <= csr_wdata_d;
            ecall_q     <= ecall_d;
            mret_q      <= mret_d;
            ebreak_q    <= ebreak_d;
            pc_q        <= pc_d;
            dnpc_q      <= dnpc_d;
            npc_q       <= npc_d;
            cnt_q       <= cnt_d;
            halt_q      <= halt_d;
        end
    end

endmodule

// File: tb/tb_ysyx_25020037_wbu.sv
// Bench for the write-back stage.
// Directed steps push expected commits; a negedge monitor pops and compares them.
module tb_ysyx_25020037_wbu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_valid = 1'b0;
    logic        wbu_ready;
    logic [31:0] in_pc = '0, in_dnpc = '0;
    logic [4:0]  in_rd = '0;
    logic        in_gpr_wen = 0, in_is_load = 0, in_is_csr = 0;
    logic [2:0]  in_ld_funct3 = '0;
    logic [1:0]  in_addr_lo = '0;
    logic [31:0] in_mem_rdata = '0, in_alu_result = '0;
    logic [31:0] in_csr_rdata = '0, in_csr_wdata = '0;
    logic [5:0]  in_csr_wen = '0;
    logic        in_ecall = 0, in_mret = 0, in_ebreak = 0;
    logic [31:0] mtvec = 32'h8000_0100, mepc = 32'h8000_0040;
    logic        wbu_valid;
    logic        gpr_ready = 1'b1;
    logic        gpr_wen;
    logic [4:0]  rd;
    logic [31:0] gpr_wdata, csr_wcsr_data, pc, npc;
    logic [5:0]  csr_wen;
    logic        ecall_en, mret_en, npc_valid, halt;
    logic [31:0] retire_cnt;

    ysyx_25020037_wbu dut (
        .clk(clk), .rst(rst), .lsu_valid(lsu_valid), .wbu_ready(wbu_ready),
        .in_pc(in_pc), .in_dnpc(in_dnpc), .in_rd(in_rd),
        .in_gpr_wen(in_gpr_wen), .in_is_load(in_is_load), .in_is_csr(in_is_csr),
        .in_ld_funct3(in_ld_funct3), .in_addr_lo(in_addr_lo),
        .in_mem_rdata(in_mem_rdata), .in_alu_result(in_alu_result),
        .in_csr_rdata(in_csr_rdata), .in_csr_wdata(in_csr_wdata),
        .in_csr_wen(in_csr_wen), .in_ecall(in_ecall), .in_mret(in_mret),
        .in_ebreak(in_ebreak), .mtvec(mtvec), .mepc(mepc),
        .wbu_valid(wbu_valid), .gpr_ready(gpr_ready), .gpr_wen(gpr_wen),
        .rd(rd), .gpr_wdata(gpr_wdata), .csr_wen(csr_wen),
        .csr_wcsr_data(csr_wcsr_data), .ecall_en(ecall_en), .mret_en(mret_en),
        .pc(pc), .npc(npc), .npc_valid(npc_valid), .retire_cnt(retire_cnt),
        .halt(halt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        gwen;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [31:0] npc;
        logic [5:0]  cwen;
        logic [31:0] cwd;
        logic        ec;
        logic        mr;
        logic [31:0] pc;
    } exp_t;

    exp_t        q[$];
    int          nvec = 0;
    int          nerr = 0;
    logic        npc_pend = 1'b0;
    logic [31:0] pend_npc = '0;
    logic [31:0] exp_cnt = '0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Commit monitor: compare the head of the scoreboard on every commit,
    // then check the redirect pc and retire count one edge later.
    always @(negedge clk) begin
        if (!rst) begin
            npc_pend = 1'b0;
            exp_cnt  = '0;
        end else begin
            if (npc_pend) begin
                check("npc", npc, pend_npc);
                check("retire_cnt", retire_cnt, exp_cnt);
                npc_pend = 1'b0;
            end
            if (wbu_valid && gpr_ready) begin
                check("npc_valid", {31'h0, npc_valid}, 32'h1);
                if (q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $error("FAIL unexpected_commit: observed pc %h expected none", pc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("gpr_wen", {31'h0, gpr_wen}, {31'h0, e.gwen});
                    check("rd", {27'h0, rd}, {27'h0, e.rd});
                    check("gpr_wdata", gpr_wdata, e.wd);
                    check("csr_wen", {26'h0, csr_wen}, {26'h0, e.cwen});
                    check("csr_wdata", csr_wcsr_data, e.cwd);
                    check("ecall_en", {31'h0, ecall_en}, {31'h0, e.ec});
                    check("mret_en", {31'h0, mret_en}, {31'h0, e.mr});
                    check("pc", pc, e.pc);
                    pend_npc = e.npc;
                    npc_pend = 1'b1;
                    exp_cnt  = exp_cnt + 32'd1;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one instruction until accepted; caller is at posedge+1.
    task automatic send(
        input logic [31:0] pc_i, input logic [31:0] dnpc_i,
        input logic [4:0] rd_i, input logic gwen_i,
        input logic ld_i, input logic csr_i,
        input logic [2:0] f3_i, input logic [1:0] alo_i,
        input logic [31:0] rdata_i, input logic [31:0] alu_i,
        input logic [31:0] crd_i, input logic [31:0] cwd_i,
        input logic [5:0] cwen_i,
        input logic ec_i, input logic mr_i, input logic eb_i,
        input logic [31:0] exp_wd, input logic exp_gwen, input bit push);
        exp_t e;
        logic rdy;
        bit   ok;
        in_pc = pc_i;       in_dnpc = dnpc_i;
        in_rd = rd_i;       in_gpr_wen = gwen_i;
        in_is_load = ld_i;  in_is_csr = csr_i;
        in_ld_funct3 = f3_i; in_addr_lo = alo_i;
        in_mem_rdata = rdata_i; in_alu_result = alu_i;
        in_csr_rdata = crd_i;   in_csr_wdata = cwd_i;
        in_csr_wen = cwen_i;
        in_ecall = ec_i; in_mret = mr_i; in_ebreak = eb_i;
        lsu_valid = 1'b1;
        e.gwen = exp_gwen; e.rd = rd_i; e.wd = exp_wd;
        e.npc = ec_i ? mtvec : (mr_i ? mepc : dnpc_i);
        e.cwen = cwen_i; e.cwd = cwd_i; e.ec = ec_i; e.mr = mr_i;
        e.pc = pc_i;
        if (push) q.push_back(e);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rdy = wbu_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1;
                break;
            end
        end
        lsu_valid = 1'b0;
        if (!ok) begin
            nvec++;
            nerr++;
            $error("FAIL accept_timeout: observed no accept expected accept");
        end else begin
            check("latency_valid", {31'h0, wbu_valid}, 32'h1);
        end
    endtask

    initial begin
        #2 rst = 1'b0;
        #1;
        check("rst_valid", {31'h0, wbu_valid}, 32'h0);
        check("rst_ready", {31'h0, wbu_ready}, 32'h1);
        check("rst_npc", npc, 32'h3000_0000);
        check("rst_cnt", retire_cnt, 32'h0);
        check("rst_halt", {31'h0, halt}, 32'h0);
        check("rst_gpr_wen", {31'h0, gpr_wen}, 32'h0);
        idle(2);
        rst = 1'b1;
        idle(1);

        // ALU write
        send(32'h3000_0000, 32'h3000_0004, 5'd5, 1, 0, 0, 3'd0, 2'd0,
             32'h0, 32'h1234, 32'h0, 32'h0, 6'h0, 0, 0, 0,
             32'h1234, 1, 1);
        idle(2);
        // Loads from 0x80F1_7F22
        send(32'h3000_0004, 32'h3000_0008, 5'd6, 1, 1, 0, 3'b000, 2'd3,
             32'h80F1_7F22, 32'hDEAD, 32'h0, 32'h0, 6'h0, 0, 0, 0,
             32'hFFFF_FF80, 1, 1);
        idle(2);
        send(32'h3000_0008, 32'h3000_000C, 5'd7, 1, 1, 0, 3'b100, 2'd1,
             32'h80F1_7F22, 32'hDEAD, 32'h0, 32'h0, 6'h0, 0, 0, 0,
             32'h0000_007F, 1, 1);
        idle(2);
        send(32'h3000_000C, 32'h3000_0010, 5'd8, 1, 1, 0, 3'b001, 2'd2,
             32'h80F1_7F22, 32'hDEAD, 32'h0, 32'h0, 6'h0, 0, 0, 0,
             32'hFFFF_80F1, 1, 1);
        idle(2);
        send(32'h3000_0010, 32'h3000_0014, 5'd9, 1, 1, 0, 3'b010, 2'd3,
             32'h80F1_7F22, 32'hDEAD, 32'h0, 32'h0, 6'h0, 0, 0, 0,
             32'h80F1_7F22, 1, 1);
        idle(2);
        send(32'h3000_0014, 32'h3000_0018, 5'd10, 1, 1, 0, 3'b101, 2'd0,
             32'h80F1_7F22, 32'hDEAD, 32'h0, 32'h0, 6'h0, 0, 0, 0,
             32'h0000_7F22, 1, 1);
        idle(2);
        send(32'h3000_0018, 32'h3000_001C, 5'd11, 1, 1, 0, 3'b011, 2'd0,
             32'h80F1_7F22, 32'hDEAD, 32'h0, 32'h0, 6'h0, 0, 0, 0,
             32'h0, 1, 1);
        idle(2);
        // rd=0 never writes
        send(32'h3000_001C, 32'h3000_0020, 5'd0, 1, 0, 0, 3'd0, 2'd0,
             32'h0, 32'h55, 32'h0, 32'h0, 6'h0, 0, 0, 0,
             32'h55, 0, 1);
        idle(2);
        // CSR read/write
        send(32'h3000_0020, 32'h3000_0024, 5'd12, 1, 0, 1, 3'd0, 2'd0,
             32'h0, 32'h77, 32'hCAFE, 32'hBEEF, 6'b000100, 0, 0, 0,
             32'hCAFE, 1, 1);
        idle(2);
        // ecall, mret, both
        send(32'h3000_0024, 32'h3000_0028, 5'd0, 0, 0, 0, 3'd0, 2'd0,
             32'h0, 32'h0, 32'h0, 32'h3000_0024, 6'b010000, 1, 0, 0,
             32'h0, 0, 1);
        idle(2);
        send(32'h8000_0100, 32'h8000_0104, 5'd0, 0, 0, 0, 3'd0, 2'd0,
             32'h0, 32'h0, 32'h0, 32'h0, 6'h0, 0, 1, 0,
             32'h0, 0, 1);
        idle(2);
        send(32'h8000_0044, 32'h8000_0048, 5'd0, 0, 0, 0, 3'd0, 2'd0,
             32'h0, 32'h0, 32'h0, 32'h0, 6'h0, 1, 1, 0,
             32'h0, 0, 1);
        idle(2);

        // Backpressure then back-to-back
        gpr_ready = 1'b0;
        send(32'h3000_0100, 32'h3000_0104, 5'd13, 1, 0, 0, 3'd0, 2'd0,
             32'h0, 32'hA5A5, 32'h0, 32'h0, 6'h0, 0, 0, 0,
             32'hA5A5, 1, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", {31'h0, wbu_valid}, 32'h1);
            check("bp_ready", {31'h0, wbu_ready}, 32'h0);
            check("bp_wdata", gpr_wdata, 32'hA5A5);
            check("bp_pc", pc, 32'h3000_0100);
            @(posedge clk);
            #1;
        end
        gpr_ready = 1'b1;
        send(32'h3000_0104, 32'h3000_0108, 5'd14, 1, 0, 0, 3'd0, 2'd0,
             32'h0, 32'h5A5A, 32'h0, 32'h0, 6'h0, 0, 0, 0,
             32'h5A5A, 1, 1);
        idle(2);
        check("b2b_cnt", retire_cnt, 32'd14);

        // ebreak sets sticky halt and blocks capture
        send(32'h3000_0108, 32'h3000_010C, 5'd15, 1, 0, 0, 3'd0, 2'd0,
             32'h0, 32'h99, 32'h0, 32'h0, 6'h0, 0, 0, 1,
             32'h99, 1, 1);
        idle(2);
        check("halt_set", {31'h0, halt}, 32'h1);
        check("halt_ready", {31'h0, wbu_ready}, 32'h0);
        lsu_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("halt_nocap", {31'h0, wbu_valid}, 32'h0);
            @(posedge clk);
            #1;
        end
        lsu_valid = 1'b0;

        // Reset clears halt
        rst = 1'b0;
        #1;
        check("halt_clr", {31'h0, halt}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);

        // Reset mid-BUSY drops the pending instruction
        gpr_ready = 1'b0;
        send(32'h3000_0200, 32'h3000_0204, 5'd3, 1, 0, 0, 3'd0, 2'd0,
             32'h0, 32'h1111, 32'h0, 32'h2222, 6'b100000, 0, 0, 0,
             32'h1111, 1, 0);
        idle(1);
        rst = 1'b0;
        #1;
        check("mid_valid", {31'h0, wbu_valid}, 32'h0);
        check("mid_npc", npc, 32'h3000_0000);
        check("mid_cnt", retire_cnt, 32'h0);
        check("mid_gpr_wen", {31'h0, gpr_wen}, 32'h0);
        check("mid_csr_wen", {26'h0, csr_wen}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        gpr_ready = 1'b1;
        idle(3);
        check("post_valid", {31'h0, wbu_valid}, 32'h0);
        check("queue_empty", q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
